// File: rtl/spawn_scheduler_if.sv
// Spawn scheduler bus: pattern ROM read port plus the spawn request handshake.
// The scheduler is the master; the ROM and the enemy spawner form the slave side.
interface spawn_scheduler_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              spawn_valid;
  logic [1:0]        spawn_lane;
  logic [1:0]        spawn_type;
  logic              spawn_ready;

  modport master (
    output rom_addr,
    input  rom_data,
    output spawn_valid,
    output spawn_lane,
    output spawn_type,
    input  spawn_ready
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  spawn_valid,
    input  spawn_lane,
    input  spawn_type,
    output spawn_ready
  );
endinterface

// File: rtl/spawn_scheduler.sv
// Level script interpreter: walks a per-level segment of the pattern ROM and
// turns WAIT/SPAWN/NOP/END words into timed, lane-aware spawn requests.
module spawn_scheduler #(
  parameter int ADDR_W = 8,
  parameter int SEG_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          state,
  input  logic                tick,
  input  logic                pause,
  input  logic [3:0]          lane_busy,
  spawn_scheduler_if.master   bus,
  output logic                gameend,
  output logic [7:0]          spawn_count,
  output logic                busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_ISSUE  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [1:0] OP_WAIT  = 2'b00;
  localparam logic [1:0] OP_SPAWN = 2'b01;
  localparam logic [1:0] OP_NOP   = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  logic [2:0]        fsm_reg, fsm_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [5:0]        wait_cnt_reg, wait_cnt_next;
  logic              valid_reg, valid_next;
  logic [1:0]        lane_reg, lane_next;
  logic [1:0]        type_reg, type_next;
  logic              gameend_reg, gameend_next;
  logic [7:0]        count_reg, count_next;
  logic              busy_reg, busy_next;

  logic              playing;
  logic              running;
  logic [ADDR_W-1:0] pc_inc;
  logic [1:0]        issue_lane;
  logic [3:0]        lane_hit;
  logic              lane_blocked;
  logic              unused_rom_bits;

  assign playing = (state >= 4'd1) && (state <= 4'd4);
  assign running = (fsm_reg == ST_FETCH) || (fsm_reg == ST_DECODE) ||
                   (fsm_reg == ST_WAIT)  || (fsm_reg == ST_ISSUE);

  // Increment only the offset bits so a script without END loops in its own level.
  assign pc_inc = {pc_reg[ADDR_W-1:SEG_W], pc_reg[SEG_W-1:0] + {{(SEG_W-1){1'b0}}, 1'b1}};

  // The lane is checked in DECODE straight from the ROM word, then from the latched copy.
  assign issue_lane = (fsm_reg == ST_DECODE) ? bus.rom_data[5:4] : lane_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_hit[gi] = lane_busy[gi] && (issue_lane == 2'(gi));
    end
  endgenerate

  assign lane_blocked    = |lane_hit;
  assign unused_rom_bits = ^bus.rom_data[1:0];

  always_comb begin
    fsm_next      = fsm_reg;
    pc_next       = pc_reg;
    wait_cnt_next = wait_cnt_reg;
    valid_next    = valid_reg;
    lane_next     = lane_reg;
    type_next     = type_reg;
    gameend_next  = 1'b0;
    count_next    = count_reg;

    case (fsm_reg)
      ST_IDLE: begin
        if (playing) begin
          fsm_next   = ST_FETCH;
          pc_next    = {state[1:0] - 2'd1, {SEG_W{1'b0}}};
          count_next = 8'd0;
        end
      end
      ST_FETCH: fsm_next = ST_DECODE;
      ST_DECODE: begin
        case (bus.rom_data[7:6])
          OP_WAIT: begin
            if (bus.rom_data[5:0] == 6'd0) begin
              pc_next  = pc_inc;
              fsm_next = ST_FETCH;
            end else begin
              wait_cnt_next = bus.rom_data[5:0];
              fsm_next      = ST_WAIT;
            end
          end
          OP_SPAWN: begin
            lane_next  = bus.rom_data[5:4];
            type_next  = bus.rom_data[3:2];
            valid_next = !lane_blocked && !pause;
            fsm_next   = ST_ISSUE;
          end
          OP_NOP: begin
            pc_next  = pc_inc;
            fsm_next = ST_FETCH;
          end
          OP_END: begin
            gameend_next = 1'b1;
            fsm_next     = ST_DONE;
          end
          default: fsm_next = ST_DONE;
        endcase
      end
      ST_WAIT: begin
        if (tick && !pause) begin
          if (wait_cnt_reg <= 6'd1) begin
            wait_cnt_next = 6'd0;
            pc_next       = pc_inc;
            fsm_next      = ST_FETCH;
          end else begin
            wait_cnt_next = wait_cnt_reg - 6'd1;
          end
        end
      end
      ST_ISSUE: begin
        // Once raised, valid is held until the consumer takes it.
        if (valid_reg) begin
          if (bus.spawn_ready) begin
            valid_next = 1'b0;
            count_next = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;
            pc_next    = pc_inc;
            fsm_next   = ST_FETCH;
          end
        end else if (!lane_blocked && !pause) begin
          valid_next = 1'b1;
        end
      end
      ST_DONE: begin
        if (!playing) fsm_next = ST_IDLE;
      end
      default: fsm_next = ST_IDLE;
    endcase

    if (running && !playing) begin
      fsm_next     = ST_IDLE;
      valid_next   = 1'b0;
      gameend_next = 1'b0;
      count_next   = count_reg;
      pc_next      = pc_reg;
    end
  end

  assign busy_next = (fsm_next != ST_IDLE) && (fsm_next != ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg      <= ST_IDLE;
      pc_reg       <= '0;
      wait_cnt_reg <= 6'd0;
      valid_reg    <= 1'b0;
      lane_reg     <= 2'd0;
      type_reg     <= 2'd0;
      gameend_reg  <= 1'b0;
      count_reg    <= 8'd0;
      busy_reg     <= 1'b0;
    end else begin
      fsm_reg      <= fsm_next;
      pc_reg       <= pc_next;
      wait_cnt_reg <= wait_cnt_next;
      valid_reg    <= valid_next;
      lane_reg     <= lane_next;
      type_reg     <= type_next;
      gameend_reg  <= gameend_next;
      count_reg    <= count_next;
      busy_reg     <= busy_next;
    end
  end

  assign bus.rom_addr    = pc_reg;
  assign bus.spawn_valid = valid_reg;
  assign bus.spawn_lane  = lane_reg;
  assign bus.spawn_type  = type_reg;
  assign gameend         = gameend_reg;
  assign spawn_count     = count_reg;
  assign busy            = busy_reg;

endmodule

// File: doc/spawn_scheduler.md
SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

Interface
REQ-001 Parameter: ADDR_W, 8, pattern ROM address width; two MSBs select the level segment.
REQ-002 Parameter: SEG_W, 6, log2 of the level segment size; ADDR_W = SEG_W + 2.
REQ-003 Port: clk  in  1  system clock; all logic on its rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: state  in  4  top-level game state; 1=EASY, 2=NORMAL, 3=HARD, 4=INFERNO; any other value = not playing.
REQ-006 Port: tick  in  1  one-cycle script step pulse, at most one every 2 cycles.
REQ-007 Port: pause  in  1  freezes tick consumption and new issue while high.
REQ-008 Port: rom_addr  out  ADDR_W  pattern ROM address.
REQ-009 Port: rom_data  in  8  ROM word, valid exactly 1 cycle after rom_addr.
REQ-010 Port: lane_busy  in  4  per-lane occupancy, bit i = lane i.
REQ-011 Port: spawn_valid  out  1  spawn request valid.
REQ-012 Port: spawn_lane  out  2  target lane.
REQ-013 Port: spawn_type  out  2  enemy type.
REQ-014 Port: spawn_ready  in  1  consumer accepts the request.
REQ-015 Port: gameend  out  1  one-cycle pulse when the script finishes.
REQ-016 Port: spawn_count  out  8  spawns accepted this run, saturating.
REQ-017 Port: busy  out  1  high in any state except IDLE and DONE.

Function
REQ-018 FSM states: IDLE, FETCH, DECODE, WAIT, ISSUE, DONE.
REQ-019 ROM word format:
  - [7:6]=00 WAIT n=[5:0] ticks
  - 01 SPAWN lane=[5:4] type=[3:2]
  - 10 NOP
  - 11 END
REQ-020 IDLE -> FETCH when state is in 1..4; load pc = {state-1, SEG_W'b0} and clear spawn_count in the same cycle.
REQ-021 FETCH: drive rom_addr=pc for one cycle, then go to DECODE.
REQ-022 DECODE actions by opcode:
  - WAIT with n=0: pc+1, back to FETCH, no tick consumed.
  - WAIT with n>0: load wait counter = n, go to WAIT.
  - NOP: pc+1, go to FETCH.
  - SPAWN: go to ISSUE.
  - END: go to DONE.
REQ-023 WAIT: each tick with pause low decrements the counter; the tick that brings it from 1 to 0 does pc+1 -> FETCH. A tick in the DECODE cycle that loads the counter is ignored.
REQ-024 ISSUE with lane_busy[lane] high or pause high: spawn_valid stays low (stall, no timeout).
REQ-025 ISSUE otherwise: spawn_valid=1 with spawn_lane/spawn_type held stable until spawn_valid & spawn_ready.
REQ-026 On acceptance: spawn_valid low the next cycle, spawn_count+1 (holds at 255), pc+1, go to FETCH.
REQ-027 Once asserted, spawn_valid does not drop on lane_busy or pause changes; only acceptance, abort or rst drop it.
REQ-028 pc increment wraps within the segment: only pc[SEG_W-1:0] increments; segment bits never change during a run.
REQ-029 Entering DONE pulses gameend for exactly 1 cycle; DONE holds until state leaves 1..4, then IDLE.
REQ-030 Abort: state outside 1..4 while busy -> IDLE next cycle; spawn_valid low that cycle even without acceptance; spawn_count retained.
REQ-031 A state change between two playing levels is not a restart; the run continues in its original segment.
REQ-032 rom_addr=pc in all states; outputs are registered, no combinational path from inputs to outputs except none.

Reset
REQ-033 rst high at a clock edge: IDLE, pc=0, wait counter=0, spawn_valid=0, spawn_lane=0, spawn_type=0, gameend=0, spawn_count=0, busy=0.
REQ-034 rst overrides every concurrent event, including acceptance, tick and END.

Verification
REQ-035 Entry: state 0->2, ROM[0x40]=0x54 (SPAWN lane1 type1), ROM[0x41]=0xC0 -> rom_addr 0x40, spawn_valid 3 cycles after the state change; after ready, gameend pulses once and spawn_count=1.
REQ-036 WAIT: ROM[0x00]=0x03 (WAIT 3) -> FETCH of 0x01 only after the 3rd tick; a tick coincident with DECODE is not counted.
REQ-037 Backpressure: lane_busy=4'b0100 with SPAWN lane2 -> no valid; drop busy -> valid; hold ready=0 for 5 cycles -> lane/type stable; ready=1 -> count increments once.
REQ-038 Wrap: segment 3 with no END, pc at 0xFF NOP -> next fetch 0xC0, not 0x00.
REQ-039 Abort: state 3->5 while spawn_valid=1 -> spawn_valid=0 and busy=0 next cycle, no gameend.
REQ-040 Reset mid-run: rst in WAIT with counter 20 -> all REQ-033 values next cycle; a new run starts only on the next state entry.
